// File: rtl/vedic_arb_pkg.sv
// -----------------------------------------------------------------------------
// vedic_arb_pkg: shared widths, FSM encoding and Vedic partial-product helpers
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package vedic_arb_pkg;

  localparam int OPND_W = 8;
  localparam int PROD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // Urdhva-Tiryakbhyam 2x2 cell: vertical and crosswise products with half-adders
  function automatic logic [3:0] vedic_2x2(input logic [1:0] a, input logic [1:0] b);
    logic s1, c1, s2, c2;
    s1 = (a[1] & b[0]) ^ (a[0] & b[1]);
    c1 = (a[1] & b[0]) & (a[0] & b[1]);
    s2 = (a[1] & b[1]) ^ c1;
    c2 = (a[1] & b[1]) & c1;
    return {c2, s2, s1, a[0] & b[0]};
  endfunction

  function automatic logic [7:0] vedic_4x4(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] q0, q1, q2, q3;
    q0 = vedic_2x2(a[1:0], b[1:0]);
    q1 = vedic_2x2(a[3:2], b[1:0]);
    q2 = vedic_2x2(a[1:0], b[3:2]);
    q3 = vedic_2x2(a[3:2], b[3:2]);
    return {4'b0, q0} + ({4'b0, q1} << 2) + ({4'b0, q2} << 2) + {q3, 4'b0};
  endfunction

endpackage

`default_nettype wire

// File: rtl/vedic_mult_arbiter_if.sv
// -----------------------------------------------------------------------------
// vedic_mult_arbiter_if: requester and response handshake bundle
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

interface vedic_mult_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) ();
  import vedic_arb_pkg::*;

  logic [NUM_REQ-1:0]        req_valid;
  logic [OPND_W*NUM_REQ-1:0] req_a;
  logic [OPND_W*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      resp_valid;
  logic                      resp_ready;
  logic [ID_W-1:0]           resp_id;
  logic [PROD_W-1:0]         resp_result;

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_result
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_result
  );

endinterface

`default_nettype wire

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter: round-robin pick, searching upward from the slot after ptr
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  int   idx;
  logic found;

  // k runs 1..NUM_REQ so ptr itself is checked last; modulo handles non-power-of-2 counts
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/vedic_8x8.sv
// -----------------------------------------------------------------------------
// vedic_8x8: combinational 8x8 unsigned Vedic multiplier built from 4x4 cells
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module vedic_8x8
  import vedic_arb_pkg::*;
(
  input  logic [OPND_W-1:0] a,
  input  logic [OPND_W-1:0] b,
  output logic [PROD_W-1:0] p
);

  logic [7:0] q0, q1, q2, q3;

  always_comb begin
    q0 = vedic_4x4(a[3:0], b[3:0]);
    q1 = vedic_4x4(a[7:4], b[3:0]);
    q2 = vedic_4x4(a[3:0], b[7:4]);
    q3 = vedic_4x4(a[7:4], b[7:4]);
    p  = {8'b0, q0} + ({8'b0, q1} << 4) + ({8'b0, q2} << 4) + {q3, 8'b0};
  end

endmodule

`default_nettype wire

// File: rtl/vedic_mult_arbiter.sv
// -----------------------------------------------------------------------------
// vedic_mult_arbiter: round-robin sharing of one vedic_8x8 among NUM_REQ users
// Rev 1.0 | optional perf counters enabled by VEDIC_ARB_PERF_EN
// -----------------------------------------------------------------------------
`default_nettype none

module vedic_mult_arbiter
  import vedic_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  vedic_mult_arbiter_if.slave  bus
`ifdef VEDIC_ARB_PERF_EN
  ,
  output logic [31:0]          perf_ops,
  output logic [31:0]          perf_stall
`endif
);

  arb_state_t         state;
  logic [ID_W-1:0]    rr_ptr;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic [OPND_W-1:0]  sel_a, sel_b;
  logic [OPND_W-1:0]  op_a, op_b;
  logic [PROD_W-1:0]  product;
  logic               resp_valid_q;
  logic [ID_W-1:0]    resp_id_q;
  logic [PROD_W-1:0]  resp_result_q;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req       (bus.req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  vedic_8x8 u_mul (
    .a (op_a),
    .b (op_b),
    .p (product)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_a = bus.req_a[i*OPND_W +: OPND_W];
        sel_b = bus.req_b[i*OPND_W +: OPND_W];
      end
    end
  end

  // Gated by rst so the accept strobe stays quiet while reset is held
  assign bus.req_ready   = (state == IDLE && !rst) ? grant : '0;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_id     = resp_id_q;
  assign bus.resp_result = resp_result_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rr_ptr        <= ID_W'(NUM_REQ - 1);
      op_a          <= '0;
      op_b          <= '0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= '0;
      resp_result_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req_valid) begin
            op_a      <= sel_a;
            op_b      <= sel_b;
            resp_id_q <= grant_idx;
            state     <= MUL;
          end
        end
        MUL: begin
          resp_result_q <= product;
          resp_valid_q  <= 1'b1;
          state         <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            rr_ptr       <= resp_id_q;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VEDIC_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ops   <= '0;
      perf_stall <= '0;
    end else if (state == RESP) begin
      if (bus.resp_ready) perf_ops   <= perf_ops + 32'd1;
      else                perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_vedic_mult_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vedic_mult_arbiter: randomized self-checking bench with a round-robin model
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_vedic_mult_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vedic_mult_arbiter_if #(.NUM_REQ(N), .ID_W(IW)) bus ();

`ifdef VEDIC_ARB_PERF_EN
  logic [31:0] perf_ops, perf_stall;
`endif

  vedic_mult_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef VEDIC_ARB_PERF_EN
    ,
    .perf_ops   (perf_ops),
    .perf_stall (perf_stall)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;
  int model_ptr;
  logic [7:0] opa [N];
  logic [7:0] opb [N];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_operands();
    for (int i = 0; i < N; i++) begin
      opa[i] = 8'($urandom);
      opb[i] = 8'($urandom);
      bus.req_a[8*i +: 8] = opa[i];
      bus.req_b[8*i +: 8] = opb[i];
    end
  endtask

  // Next winner: first asserted requester strictly after the last one served
  function automatic int model_grant(input logic [N-1:0] mask);
    for (int k = 1; k <= N; k++) begin
      if (mask[(model_ptr + k) % N]) return (model_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int g);
    logic [N-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  function automatic logic [15:0] prod(input int g);
    return 16'(int'(opa[g]) * int'(opb[g]));
  endfunction

  task automatic test_reset();
    int g;
    rst = 1'b1;
    bus.req_valid = '1;
    bus.resp_ready = 1'b1;
    drive_operands();
    repeat (3) begin
      step();
      n_cmp++;
      if ({bus.req_ready, bus.resp_valid, bus.resp_id, bus.resp_result} !== '0) begin
        n_err++;
        $display("FAIL reset_outputs: got ready=%b valid=%b id=%0d result=%h, want all 0",
                 bus.req_ready, bus.resp_valid, bus.resp_id, bus.resp_result);
      end
    end
    rst = 1'b0;
    model_ptr = N - 1;
    #1;
    g = model_grant(bus.req_valid);
    n_cmp++;
    if (bus.req_ready !== onehot(g)) begin
      n_err++;
      $display("FAIL reset_first_grant: got %b want %b", bus.req_ready, onehot(g));
    end
    step();
    bus.req_valid = '0;
    step();
    n_cmp++;
    if (bus.resp_valid !== 1'b1 || bus.resp_id !== IW'(g) || bus.resp_result !== prod(g)) begin
      n_err++;
      $display("FAIL reset_first_resp: got v=%b id=%0d r=%h want v=1 id=%0d r=%h",
               bus.resp_valid, bus.resp_id, bus.resp_result, g, prod(g));
    end
    step();
    model_ptr = g;
  endtask

  task automatic test_single_op();
    bus.req_valid = 4'b0100;
    opa[2] = 8'd13; opb[2] = 8'd11;
    bus.req_a[23:16] = 8'd13;
    bus.req_b[23:16] = 8'd11;
    bus.resp_ready = 1'b1;
    #1;
    n_cmp++;
    if (bus.req_ready !== 4'b0100) begin
      n_err++;
      $display("FAIL single_ready: got %b want 0100", bus.req_ready);
    end
    step();
    bus.req_valid = '0;
    #1;
    n_cmp++;
    if (bus.req_ready !== '0 || bus.resp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_mul_cycle: got ready=%b valid=%b want 0/0", bus.req_ready, bus.resp_valid);
    end
    step();
    n_cmp++;
    if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd2 || bus.resp_result !== 16'd143) begin
      n_err++;
      $display("FAIL single_resp: got v=%b id=%0d r=%0d want v=1 id=2 r=143",
               bus.resp_valid, bus.resp_id, bus.resp_result);
    end
    step();
    n_cmp++;
    if (bus.resp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_release: got valid=%b want 0", bus.resp_valid);
    end
    model_ptr = 2;
  endtask

  task automatic test_round_robin();
    int g;
    rst = 1'b1;
    bus.req_valid = '0;
    step();
    rst = 1'b0;
    model_ptr = N - 1;
    bus.req_valid = '1;
    bus.resp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive_operands();
      #1;
      g = model_grant(bus.req_valid);
      n_cmp++;
      if (bus.req_ready !== onehot(g) || g != (k % N)) begin
        n_err++;
        $display("FAIL rr_grant[%0d]: got %b want %b", k, bus.req_ready, onehot(k % N));
      end
      step();
      n_cmp++;
      if (bus.req_ready !== '0) begin
        n_err++;
        $display("FAIL rr_mul_ready[%0d]: got %b want 0", k, bus.req_ready);
      end
      step();
      n_cmp++;
      if (bus.resp_valid !== 1'b1 || bus.resp_id !== IW'(g) || bus.resp_result !== prod(g)) begin
        n_err++;
        $display("FAIL rr_resp[%0d]: got v=%b id=%0d r=%h want v=1 id=%0d r=%h",
                 k, bus.resp_valid, bus.resp_id, bus.resp_result, g, prod(g));
      end
      step();
      model_ptr = g;
    end
    bus.req_valid = '0;
  endtask

  task automatic test_backpressure();
    int r, g;
    r = $urandom_range(0, N - 1);
    opa[r] = 8'hFF; opb[r] = 8'hFF;
    bus.req_a[8*r +: 8] = 8'hFF;
    bus.req_b[8*r +: 8] = 8'hFF;
    bus.req_valid = onehot(r);
    bus.resp_ready = 1'b0;
    step();
    bus.req_valid = '1;
    step();
    repeat (5) begin
      n_cmp++;
      if (bus.resp_valid !== 1'b1 || bus.resp_result !== 16'hFE01 || bus.resp_id !== IW'(r)
          || bus.req_ready !== '0) begin
        n_err++;
        $display("FAIL bp_hold: got v=%b r=%h id=%0d ready=%b want v=1 r=fe01 id=%0d ready=0",
                 bus.resp_valid, bus.resp_result, bus.resp_id, bus.req_ready, r);
      end
      step();
    end
    bus.resp_ready = 1'b1;
    #1;
    n_cmp++;
    if (bus.req_ready !== '0 || bus.resp_valid !== 1'b1) begin
      n_err++;
      $display("FAIL bp_handshake: got ready=%b valid=%b want 0/1", bus.req_ready, bus.resp_valid);
    end
    step();
    model_ptr = r;
    g = model_grant(bus.req_valid);
    n_cmp++;
    if (bus.req_ready !== onehot(g)) begin
      n_err++;
      $display("FAIL bp_next_grant: got %b want %b", bus.req_ready, onehot(g));
    end
    bus.req_valid = '0;
    #1;
    step();
    n_cmp++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== '0) begin
      n_err++;
      $display("FAIL bp_withdrawn: got valid=%b ready=%b want 0/0", bus.resp_valid, bus.req_ready);
    end
    step();
    n_cmp++;
    if (bus.resp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_no_capture: got valid=%b want 0", bus.resp_valid);
    end
  endtask

  task automatic test_reset_mid_op();
    bus.req_valid = 4'b1000;
    bus.resp_ready = 1'b1;
    drive_operands();
    step();
    rst = 1'b1;
    bus.req_valid = '0;
    step();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (bus.resp_valid !== 1'b0) begin
        n_err++;
        $display("FAIL midrst_no_resp[%0d]: got valid=%b want 0", k, bus.resp_valid);
      end
      step();
    end
    model_ptr = N - 1;
    bus.req_valid = '1;
    #1;
    n_cmp++;
    if (bus.req_ready !== onehot(model_grant(bus.req_valid))) begin
      n_err++;
      $display("FAIL midrst_grant: got %b want 0001", bus.req_ready);
    end
    bus.req_valid = '0;
    step();
  endtask

  task automatic test_random();
    logic [N-1:0] mask;
    int g, stall;
    for (int t = 0; t < 24; t++) begin
      mask = N'($urandom_range(0, (1 << N) - 1));
      drive_operands();
      bus.req_valid = mask;
      bus.resp_ready = 1'b1;
      #1;
      g = model_grant(mask);
      n_cmp++;
      if (bus.req_ready !== onehot(g)) begin
        n_err++;
        $display("FAIL rand_grant[%0d]: mask=%b got %b want %b", t, mask, bus.req_ready, onehot(g));
      end
      step();
      if (g < 0) continue;
      bus.req_valid = N'($urandom);
      #1;
      n_cmp++;
      if (bus.req_ready !== '0) begin
        n_err++;
        $display("FAIL rand_mul_ready[%0d]: got %b want 0", t, bus.req_ready);
      end
      step();
      stall = $urandom_range(0, 3);
      bus.resp_ready = 1'b0;
      for (int s = 0; s <= stall; s++) begin
        if (s == stall) bus.resp_ready = 1'b1;
        n_cmp++;
        if (bus.resp_valid !== 1'b1 || bus.resp_id !== IW'(g) || bus.resp_result !== prod(g)) begin
          n_err++;
          $display("FAIL rand_resp[%0d]: got v=%b id=%0d r=%h want v=1 id=%0d r=%h",
                   t, bus.resp_valid, bus.resp_id, bus.resp_result, g, prod(g));
        end
        step();
      end
      model_ptr = g;
    end
    bus.req_valid = '0;
  endtask

`ifdef VEDIC_ARB_PERF_EN
  task automatic test_perf();
    rst = 1'b1;
    bus.req_valid = '0;
    step();
    rst = 1'b0;
    n_cmp++;
    if (perf_ops !== 32'd0 || perf_stall !== 32'd0) begin
      n_err++;
      $display("FAIL perf_reset: got ops=%0d stall=%0d want 0/0", perf_ops, perf_stall);
    end
    for (int k = 0; k < 3; k++) begin
      drive_operands();
      bus.req_valid = onehot($urandom_range(0, N - 1));
      bus.resp_ready = 1'b1;
      step();
      bus.req_valid = '0;
      step();
      if (k == 1) begin
        bus.resp_ready = 1'b0;
        repeat (4) step();
        bus.resp_ready = 1'b1;
      end
      step();
    end
    n_cmp++;
    if (perf_ops !== 32'd3 || perf_stall !== 32'd4) begin
      n_err++;
      $display("FAIL perf_counts: got ops=%0d stall=%0d want 3/4", perf_ops, perf_stall);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.resp_ready = 1'b0;
    test_reset();
    test_single_op();
    test_round_robin();
    test_backpressure();
    test_reset_mid_op();
    test_random();
`ifdef VEDIC_ARB_PERF_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
